// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- four-digit multiplexed 7-segment scan controller.
//
// A new BCD value is captured into a pending register on load and is
// promoted to the display register only at the digit-3 -> digit-0 wrap,
// so a frame never shows a mix of old and new digits. Each digit slot
// consists of GUARD all-off cycles followed by SCAN_DIV lit cycles.
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-high
//   load       capture request for value (sampled every edge)
//   value      four BCD nibbles, [3:0] = digit 0 (rightmost)
//   blank_lz   leading-zero blanking enable, used live
//   ack        one-cycle pulse after each captured load
//   bcd        nibble for the shared 7-segment decoder
//   digit_en   active-low one-hot digit enables, bit k = digit k
//   frame_done one-cycle pulse after each digit 3 -> 0 wrap
//
// Handshake: load has no back-pressure. Every edge that sees load=1
// captures value, and ack is high in the cycle after that edge. Repeated
// loads before a wrap simply overwrite the pending value.
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic        ack,
  output logic [3:0]  bcd,
  output logic [3:0]  digit_en,
  output logic        frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [GW-1:0] GRD_LAST = GW'(GUARD - 1);

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [GW-1:0] guard_cnt;
  logic [PW-1:0] pre_cnt;
  logic [1:0]    idx;
  logic [15:0]   pend_val;
  logic          pend;
  logic [15:0]   disp;

  logic          guard_done;
  logic          slot_done;
  logic          wrap;
  logic [3:0]    nib;
  logic          lead_zero;
  logic          blank;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_GUARD;
    else       state <= state_next;
  end

  // Next state, slot timing strobes and display outputs
  always_comb begin
    state_next = state;
    guard_done = 1'b0;
    slot_done  = 1'b0;
    digit_en   = 4'b1111;

    case (state)
      ST_GUARD: begin
        if (guard_cnt == GRD_LAST) begin
          guard_done = 1'b1;
          state_next = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (pre_cnt == PRE_LAST) begin
          slot_done  = 1'b1;
          state_next = ST_GUARD;
        end
      end
      default: state_next = ST_GUARD;
    endcase

    wrap = slot_done && (idx == 2'd3);

    // bcd follows the index in both states so the decoder has settled
    // by the time the digit is switched on.
    nib = disp[{idx, 2'b00} +: 4];
    bcd = nib;

    // A digit is a leading zero when it and every digit above it are zero;
    // digit 0 is never treated as leading.
    case (idx)
      2'd1:    lead_zero = (disp[15:4] == 12'h000);
      2'd2:    lead_zero = (disp[15:8] == 8'h00);
      2'd3:    lead_zero = (disp[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase

    blank = (nib > 4'd9) || (blank_lz && lead_zero);

    if (state == ST_SHOW && !blank) digit_en = ~(4'b0001 << idx);
  end

  // Counters, digit index and value registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      guard_cnt  <= '0;
      pre_cnt    <= '0;
      idx        <= 2'd0;
      pend_val   <= 16'h0000;
      pend       <= 1'b0;
      disp       <= 16'h0000;
      ack        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ack        <= load;
      frame_done <= wrap;

      if (state == ST_GUARD && !guard_done) guard_cnt <= guard_cnt + 1'b1;
      else if (slot_done)                   guard_cnt <= '0;

      if (guard_done)                          pre_cnt <= '0;
      else if (state == ST_SHOW && !slot_done) pre_cnt <= pre_cnt + 1'b1;

      if (slot_done) idx <= idx + 2'd1;

      // At a wrap the old pending value is promoted before a coincident
      // load refills pending, so neither value is lost.
      if (wrap && pend) disp <= pend_val;

      if (load) begin
        pend_val <= value;
        pend     <= 1'b1;
      end else if (wrap) begin
        pend     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with SCAN_DIV=4, GUARD=2 (6-cycle slots,
// 24-cycle frames). A frame-position model predicts every output after
// each clock edge; directed steps add literal checks at chosen positions.
module tb_seg_scan_ctrl;

  localparam int S = 4;
  localparam int G = 2;
  localparam int P = S + G;
  localparam int F = 4 * P;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic        ack;
  logic [3:0]  bcd;
  logic [3:0]  digit_en;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(S), .GUARD(G)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .ack        (ack),
    .bcd        (bcd),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  int vectors     = 0;
  int miscompares = 0;
  int ack_seen    = 0;

  // ---------------- model ----------------
  // e counts clock edges since reset release; the frame position is e mod F.
  int          e = 0;
  logic [15:0] m_pv   = 16'h0;
  logic [15:0] m_disp = 16'h0;
  bit          m_pend = 1'b0;
  bit          m_ack  = 1'b0;
  bit          m_fd   = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e = 0; m_pv = 16'h0; m_disp = 16'h0; m_pend = 1'b0;
      m_ack = 1'b0; m_fd = 1'b0;
    end else begin
      e = e + 1;
      m_fd  = ((e % F) == 0);
      m_ack = load;
      if (m_fd && m_pend) begin
        m_disp = m_pv;
        m_pend = 1'b0;
      end
      if (load) begin
        m_pv   = value;
        m_pend = 1'b1;
      end
    end
  end

  function automatic logic [3:0] exp_bcd();
    int slot;
    slot = (e % F) / P;
    return 4'((m_disp >> (4 * slot)) & 16'hF);
  endfunction

  function automatic logic [3:0] exp_en();
    int slot;
    int nibv;
    logic [3:0] one;
    one  = 4'b0001;
    slot = (e % F) / P;
    nibv = int'((m_disp >> (4 * slot)) & 16'hF);
    if (reset) return 4'b1111;
    if (((e % F) % P) < G) return 4'b1111;
    if (nibv > 9) return 4'b1111;
    if (blank_lz && slot > 0 && (m_disp >> (4 * slot)) == 16'h0) return 4'b1111;
    return ~(one << slot);
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (pos %0d, t=%0t)", name, got, exp, e % F, $time);
    end
  endtask

  // Compare process: every cycle, shortly after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("m_digit_en", {12'h0, digit_en}, {12'h0, exp_en()});
      check("m_bcd", {12'h0, bcd}, {12'h0, exp_bcd()});
      check("m_ack", {15'h0, ack}, {15'h0, m_ack});
      check("m_frame_done", {15'h0, frame_done}, {15'h0, m_fd});
      if (ack === 1'b1) ack_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pos(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((e % F) != p && n < 100);
    if ((e % F) != p) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_pos: got pos %0d expected %0d within 100 cycles", e % F, p);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [3:0] en0, input logic [3:0] b0,
                             input logic [3:0] en1, input logic [3:0] b1,
                             input logic [3:0] en2, input logic [3:0] b2,
                             input logic [3:0] en3, input logic [3:0] b3);
    wait_pos(2);  check({tag, "_en0"}, {12'h0, digit_en}, {12'h0, en0}); check({tag, "_b0"}, {12'h0, bcd}, {12'h0, b0});
    wait_pos(8);  check({tag, "_en1"}, {12'h0, digit_en}, {12'h0, en1}); check({tag, "_b1"}, {12'h0, bcd}, {12'h0, b1});
    wait_pos(14); check({tag, "_en2"}, {12'h0, digit_en}, {12'h0, en2}); check({tag, "_b2"}, {12'h0, bcd}, {12'h0, b2});
    wait_pos(20); check({tag, "_en3"}, {12'h0, digit_en}, {12'h0, en3}); check({tag, "_b3"}, {12'h0, bcd}, {12'h0, b3});
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0] seq [12];
  time        t0;
  int         ack_base;

  initial begin
    seq = '{4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1110,
            4'b1111, 4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1101};
    reset = 1'b1; load = 1'b0; value = 16'h0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en", {12'h0, digit_en}, 16'h000F);
    check("rst_bcd", {12'h0, bcd}, 16'h0000);
    check("rst_ack", {15'h0, ack}, 16'h0000);

    // Scan timing from reset release, value never loaded
    reset = 1'b0;
    #1;
    check("scan_en_0", {12'h0, digit_en}, {12'h0, seq[0]});
    for (int i = 1; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("scan_en_%0d", i), {12'h0, digit_en}, {12'h0, seq[i]});
      check($sformatf("scan_bcd_%0d", i), {12'h0, bcd}, 16'h0000);
    end

    // Load 1234 mid-frame: ack next cycle, no tearing, shown next frame
    wait_pos(10);
    do_load(16'h1234);
    check("ack_1234", {15'h0, ack}, 16'h0001);
    wait_pos(14);
    check("no_tear", {12'h0, bcd}, 16'h0000);
    wait_pos(0);
    check("fd_a", {15'h0, frame_done}, 16'h0001);
    t0 = $time;
    check_frame("f1234", 4'b1110, 4'h4, 4'b1101, 4'h3, 4'b1011, 4'h2, 4'b0111, 4'h1);
    wait_pos(0);
    check("fd_b", {15'h0, frame_done}, 16'h0001);
    check("fd_period", 16'($time - t0), 16'd240);
    wait_pos(1);
    check("fd_low", {15'h0, frame_done}, 16'h0000);

    // 0042 with leading-zero blanking, then blanking switched off live
    blank_lz = 1'b1;
    wait_pos(4);
    do_load(16'h0042);
    check_frame("f0042lz", 4'b1110, 4'h2, 4'b1101, 4'h4, 4'b1111, 4'h0, 4'b1111, 4'h0);
    wait_pos(12);
    blank_lz = 1'b0;
    wait_pos(14);
    check("f0042_en2", {12'h0, digit_en}, 16'h000B);
    wait_pos(20);
    check("f0042_en3", {12'h0, digit_en}, 16'h0007);

    // 0000 with blanking: only digit 0 lit
    blank_lz = 1'b1;
    wait_pos(4);
    do_load(16'h0000);
    check_frame("f0000", 4'b1110, 4'h0, 4'b1111, 4'h0, 4'b1111, 4'h0, 4'b1111, 4'h0);

    // Non-BCD nibble stays dark
    blank_lz = 1'b0;
    wait_pos(4);
    do_load(16'h12A4);
    check_frame("f12a4", 4'b1110, 4'h4, 4'b1111, 4'hA, 4'b1011, 4'h2, 4'b0111, 4'h1);

    // 1111 pending, then 2222 loaded exactly on the wrap edge
    wait_pos(20);
    ack_base = ack_seen;
    do_load(16'h1111);
    wait_pos(23);
    do_load(16'h2222);
    check_frame("f1111", 4'b1110, 4'h1, 4'b1101, 4'h1, 4'b1011, 4'h1, 4'b0111, 4'h1);
    check_frame("f2222", 4'b1110, 4'h2, 4'b1101, 4'h2, 4'b1011, 4'h2, 4'b0111, 4'h2);
    check("ack_twice", 16'(ack_seen - ack_base), 16'd2);

    // Asynchronous reset mid-SHOW
    wait_pos(3);
    #2 reset = 1'b1;
    #1;
    check("async_en", {12'h0, digit_en}, 16'h000F);
    check("async_bcd", {12'h0, bcd}, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset during a load: pending discarded, no late ack
    wait_pos(10);
    do_load(16'h9876);
    check("ack_9876", {15'h0, ack}, 16'h0001);
    #2 reset = 1'b1;
    #1;
    check("ack_cleared", {15'h0, ack}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    wait_pos(0);
    check_frame("fdiscard", 4'b1110, 4'h0, 4'b1101, 4'h0, 4'b1011, 4'h0, 4'b0111, 4'h0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
